// File: rtl/sipo_rx.sv
// LSB-first serial-to-parallel receiver with a 2-entry output FIFO.
// It reports truncated frames as a one-cycle frame_err pulse and dropped words through a sticky overflow flag.
module sipo_rx #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ser_in,
  input  logic             ser_en,
  input  logic             ser_start,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  input  logic             data_ready,
  output logic             busy,
  output logic             frame_err,
  output logic             overflow,
  input  logic             ovf_clr
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] shifted;
  logic             push;
  logic             frame_err_q, frame_err_d;
  logic             overflow_q, overflow_d;

  logic [WIDTH-1:0] mem_q [2];
  logic             wr_ptr_q, rd_ptr_q;
  logic [1:0]       count_q, count_d;
  logic             pop, push_ok;

  // New bits enter at the MSB, so the first bit lands in bit 0 after WIDTH shifts.
  assign shifted = {ser_in, sr_q[WIDTH-1:1]};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sr_d        = sr_q;
    push        = 1'b0;
    frame_err_d = 1'b0;
    if (ser_en) begin
      if (ser_start) begin
        frame_err_d = (state_q == SHIFT);
        sr_d        = {ser_in, {(WIDTH-1){1'b0}}};
        cnt_d       = CW'(1);
        state_d     = SHIFT;
      end else if (state_q == SHIFT) begin
        sr_d = shifted;
        if (cnt_q == CW'(WIDTH-1)) begin
          push    = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end
  end

  // Valid/ready: a word transfers on each rising edge where data_valid && data_ready.
  // data_out stays put while data_valid && !data_ready.
  assign pop     = data_valid && data_ready;
  assign push_ok = push && ((count_q != 2'd2) || pop);

  always_comb begin
    count_d    = count_q + {1'b0, push_ok} - {1'b0, pop};
    overflow_d = overflow_q;
    if (push && !push_ok) begin
      overflow_d = 1'b1;
    end else if (ovf_clr) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      sr_q        <= '0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
      count_q     <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      for (int i = 0; i < 2; i++) mem_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sr_q        <= sr_d;
      frame_err_q <= frame_err_d;
      overflow_q  <= overflow_d;
      count_q     <= count_d;
      if (push_ok) begin
        mem_q[wr_ptr_q] <= shifted;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
    end
  end

  assign data_valid = (count_q != 2'd0);
  assign data_out   = mem_q[rd_ptr_q];
  assign busy       = (state_q == SHIFT);
  assign frame_err  = frame_err_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_sipo_rx.sv
// Directed bench for sipo_rx: normal frames, gapped bits, FIFO overflow/clear,
// frame abort, simultaneous push/pop when full, and reset mid-word.
module tb_sipo_rx;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         ser_in = 1'b0;
  logic         ser_en = 1'b0;
  logic         ser_start = 1'b0;
  logic         data_ready = 1'b0;
  logic         ovf_clr = 1'b0;
  logic [W-1:0] data_out;
  logic         data_valid;
  logic         busy;
  logic         frame_err;
  logic         overflow;

  int           checks = 0;
  int           failures = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] w;

  always #5 clk = ~clk;

  sipo_rx #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .ser_in     (ser_in),
    .ser_en     (ser_en),
    .ser_start  (ser_start),
    .data_out   (data_out),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .busy       (busy),
    .frame_err  (frame_err),
    .overflow   (overflow),
    .ovf_clr    (ovf_clr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=0x%0h exp=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b, input logic st);
    ser_en    = 1'b1;
    ser_in    = b;
    ser_start = st;
    tick();
    ser_en    = 1'b0;
    ser_start = 1'b0;
    ser_in    = 1'b0;
  endtask

  // Sends a full frame; gap idle cycles follow every bit except the last.
  task automatic send_word(input logic [W-1:0] word, input int gap);
    for (int i = 0; i < W; i++) begin
      send_bit(word[i], i == 0);
      check_eq("busy", busy, (i < W-1) ? 1 : 0);
      if (i > 0) check_eq("frame_err_clean", frame_err, 0);
      if (i < W-1) begin
        for (int g = 0; g < gap; g++) begin
          tick();
          check_eq("busy_gap", busy, 1);
          check_eq("frame_err_gap", frame_err, 0);
        end
      end
    end
  endtask

  task automatic expect_head(input string tag);
    check_eq({tag, "_valid"}, data_valid, 1);
    check_eq(tag, data_out, exp_q.pop_front());
  endtask

  initial begin
    // Reset state
    repeat (2) tick();
    check_eq("rst_valid", data_valid, 0);
    check_eq("rst_data", data_out, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_frame_err", frame_err, 0);
    check_eq("rst_overflow", overflow, 0);
    rst = 1'b0;
    tick();

    // Bits without ser_start in IDLE are ignored
    for (int i = 0; i < 4; i++) begin
      send_bit(1'b1, 1'b0);
      check_eq("t0_busy", busy, 0);
      check_eq("t0_frame_err", frame_err, 0);
    end
    check_eq("t0_valid", data_valid, 0);

    // T1: continuous bits, consumer always ready
    data_ready = 1'b1;
    exp_q.push_back(16'hA5C3);
    send_word(16'hA5C3, 0);
    expect_head("t1_word");
    tick();
    check_eq("t1_drained", data_valid, 0);

    // T2: ser_en toggling every cycle
    exp_q.push_back(16'hA5C3);
    send_word(16'hA5C3, 1);
    expect_head("t2_word");
    tick();
    check_eq("t2_drained", data_valid, 0);

    // T3: consumer stalled, third word overflows
    data_ready = 1'b0;
    exp_q.push_back(16'h1111);
    exp_q.push_back(16'h2222);
    send_word(16'h1111, 0);
    check_eq("t3_first", data_out, 16'h1111);
    check_eq("t3_ovf0", overflow, 0);
    send_word(16'h2222, 0);
    check_eq("t3_ovf1", overflow, 0);
    send_word(16'h3333, 0);
    check_eq("t3_ovf_set", overflow, 1);
    check_eq("t3_head", data_out, 16'h1111);
    repeat (3) tick();
    check_eq("t3_hold", data_out, 16'h1111);
    check_eq("t3_ovf_sticky", overflow, 1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check_eq("t3_ovf_clr", overflow, 0);
    data_ready = 1'b1;
    expect_head("t3_pop1");
    tick();
    expect_head("t3_pop2");
    tick();
    check_eq("t3_empty", data_valid, 0);
    data_ready = 1'b0;

    // T4: 5-bit partial frame abandoned by a new 0xBEEF frame
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    check_eq("t4_busy_partial", busy, 1);
    check_eq("t4_no_err_yet", frame_err, 0);
    w = 16'hBEEF;
    exp_q.push_back(w);
    send_bit(w[0], 1'b1);
    check_eq("t4_frame_err", frame_err, 1);
    check_eq("t4_busy", busy, 1);
    send_bit(w[1], 1'b0);
    check_eq("t4_err_pulse", frame_err, 0);
    for (int i = 2; i < W; i++) send_bit(w[i], 1'b0);
    expect_head("t4_word");
    data_ready = 1'b1;
    tick();
    check_eq("t4_only_one", data_valid, 0);
    data_ready = 1'b0;

    // T5: FIFO full, pop on the same edge the next word completes
    exp_q.push_back(16'h5555);
    exp_q.push_back(16'h6666);
    exp_q.push_back(16'h4444);
    send_word(16'h5555, 0);
    send_word(16'h6666, 0);
    w = 16'h4444;
    send_bit(w[0], 1'b1);
    for (int i = 1; i < W-1; i++) send_bit(w[i], 1'b0);
    data_ready = 1'b1;
    expect_head("t5_pop1");
    send_bit(w[W-1], 1'b0);
    check_eq("t5_no_ovf", overflow, 0);
    expect_head("t5_pop2");
    tick();
    expect_head("t5_pop3");
    tick();
    check_eq("t5_empty", data_valid, 0);
    data_ready = 1'b0;

    // T6: reset while busy with one word queued
    send_word(16'h7777, 0);
    send_bit(1'b1, 1'b1);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    check_eq("t6_pre_busy", busy, 1);
    check_eq("t6_pre_valid", data_valid, 1);
    #2 rst = 1'b1;
    #1;
    check_eq("t6_rst_valid", data_valid, 0);
    check_eq("t6_rst_data", data_out, 0);
    check_eq("t6_rst_busy", busy, 0);
    check_eq("t6_rst_frame_err", frame_err, 0);
    check_eq("t6_rst_overflow", overflow, 0);
    tick();
    rst = 1'b0;
    tick();
    exp_q.push_back(16'h0001);
    send_word(16'h0001, 0);
    expect_head("t6_word");
    check_eq("t6_ovf", overflow, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
